// File: rtl/int_ctrl_n.sv
// Parametrised interrupt controller: synchronised edge/level sources, fixed-priority
// selection and a single-level trap entry/exit handshake with the CSR file.
module int_ctrl_n #(
  parameter int NUM_SRC     = 8,
  parameter int IDX_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   irq_edge_mode,
  input  logic [NUM_SRC-1:0]   irq_en,
  input  logic                 int_mstatus_mie,
  input  logic                 mret_en,
  output logic                 trap_entry_en,
  output logic                 trap_exit_en,
  output logic [IDX_WIDTH-1:0] int_index,
  output logic                 int_active,
  output logic [NUM_SRC-1:0]   irq_pending
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    ACTIVE = 2'd2,
    EXIT   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]   sync_d_q;
  logic [NUM_SRC-1:0]   sync_now;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   clr;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] sel;
  logic                 any_req;
  logic                 take;

  // Stage 0 captures the raw line; the last stage is the usable synchronised value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sync_d_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_src};
      sync_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_now = sync_q[SYNC_STAGES-1];
  assign rise     = sync_now & ~sync_d_q;
  assign req      = pend_q & irq_en;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel     = IDX_WIDTH'(i);
        any_req = 1'b1;
      end
    end
  end

  assign take = (state_q == IDLE) && any_req && int_mstatus_mie;

  // A fresh edge in the same cycle as the clear keeps the bit set, queueing one event.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign clr[gi]    = take && (sel == IDX_WIDTH'(gi));
    assign pend_d[gi] = irq_edge_mode[gi] ? (rise[gi] | (pend_q[gi] & ~clr[gi]))
                                          : sync_now[gi];
  end

  assign idx_d = take ? sel : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ENTRY;
      ENTRY:   state_d = ACTIVE;
      ACTIVE:  if (mret_en) state_d = EXIT;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trap_entry_en = (state_q == ENTRY);
    trap_exit_en  = (state_q == EXIT);
    int_active    = (state_q != IDLE);
  end

  assign int_index   = idx_q;
  assign irq_pending = pend_q;

endmodule

// File: tb/tb_int_ctrl_n.sv
// Bench for int_ctrl_n: directed scenarios with literal expectations plus a
// randomized run, all outputs checked every cycle against a timeline model.
module tb_int_ctrl_n;

  localparam int NS = 8;
  localparam int IW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] irq_src = '0;
  logic [NS-1:0] irq_edge_mode = '1;
  logic [NS-1:0] irq_en = '1;
  logic          int_mstatus_mie = 1'b1;
  logic          mret_en = 1'b0;
  logic          trap_entry_en;
  logic          trap_exit_en;
  logic [IW-1:0] int_index;
  logic          int_active;
  logic [NS-1:0] irq_pending;

  int compared = 0;
  int mismatched = 0;

  int_ctrl_n #(.NUM_SRC(NS), .IDX_WIDTH(IW), .SYNC_STAGES(SS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_src         (irq_src),
    .irq_edge_mode   (irq_edge_mode),
    .irq_en          (irq_en),
    .int_mstatus_mie (int_mstatus_mie),
    .mret_en         (mret_en),
    .trap_entry_en   (trap_entry_en),
    .trap_exit_en    (trap_exit_en),
    .int_index       (int_index),
    .int_active      (int_active),
    .irq_pending     (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of sampled lines, pending bits, and the trap as a timeline
  // (edge it was taken at, edge mret was accepted at).
  logic [NS-1:0] hist [0:SS];
  logic [NS-1:0] m_pend;
  logic [IW-1:0] m_idx;
  bit            m_trap;
  int            ecnt, m_taken, m_mret_edge;

  task automatic model_reset();
    for (int k = 0; k <= SS; k++) hist[k] = '0;
    m_pend = '0; m_idx = '0; m_trap = 0;
    ecnt = 0; m_taken = -100; m_mret_edge = -1;
  endtask

  task automatic model_step();
    logic [NS-1:0] s, sd, req, np;
    int  sel;
    bit  take;
    ecnt++;
    s   = hist[SS-1];
    sd  = hist[SS];
    req = m_pend & irq_en;
    sel = -1;
    for (int i = NS - 1; i >= 0; i--) if (req[i]) sel = i;
    take = !m_trap && (sel >= 0) && int_mstatus_mie;
    if (m_trap) begin
      if (m_mret_edge < 0) begin
        if (mret_en && ecnt >= m_taken + 2) m_mret_edge = ecnt;
      end else if (ecnt == m_mret_edge + 1) begin
        m_trap = 0;
      end
    end
    if (take) begin
      m_trap = 1; m_taken = ecnt; m_mret_edge = -1; m_idx = IW'(sel);
    end
    for (int i = 0; i < NS; i++) begin
      if (irq_edge_mode[i]) np[i] = (s[i] & ~sd[i]) | (m_pend[i] & !(take && sel == i));
      else                  np[i] = s[i];
    end
    m_pend = np;
    for (int k = SS; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = irq_src;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_entry",   trap_entry_en, int'(m_trap && m_taken == ecnt));
        chk("m_exit",    trap_exit_en,  int'(m_trap && m_mret_edge == ecnt));
        chk("m_active",  int_active,    int'(m_trap));
        chk("m_index",   int_index,     int'(m_idx));
        chk("m_pending", irq_pending,   int'(m_pend));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    irq_src = irq_src | m;
    cyc(2);
    irq_src = irq_src & ~m;
  endtask

  task automatic wait_entry(input string nm, input int exp_idx);
    int n = 0;
    while (trap_entry_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({nm, "_entry_timeout"}, trap_entry_en, 1);
    else         chk({nm, "_idx"}, int_index, exp_idx);
  endtask

  // Called on the entry cycle; returns one cycle after the exit pulse.
  task automatic do_mret(input string nm);
    cyc(1);
    chk({nm, "_active"}, int_active, 1);
    mret_en = 1'b1;
    cyc(1);
    mret_en = 1'b0;
    chk({nm, "_exit"}, trap_exit_en, 1);
    cyc(1);
    chk({nm, "_idle"}, int_active, 0);
  endtask

  task automatic no_entry(input string nm, input int n);
    repeat (n) begin
      cyc(1);
      chk(nm, trap_entry_en, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_entry", trap_entry_en, 0);
    chk("rst_active", int_active, 0);
    chk("rst_index", int_index, 0);
    chk("rst_pending", irq_pending, 0);
    rst_n = 1'b1;
    cyc(3);

    // 1: single edge source, exact latency
    irq_src[3] = 1'b1;
    cyc(2);
    irq_src[3] = 1'b0;
    cyc(2);
    chk("t1_entry", trap_entry_en, 1);
    chk("t1_idx", int_index, 3);
    chk("t1_pend3", irq_pending[3], 0);
    do_mret("t1");
    cyc(3);

    // 2: simultaneous sources 5 and 2
    pulse(8'h24);
    wait_entry("t2a", 2);
    do_mret("t2a");
    wait_entry("t2b", 5);
    do_mret("t2b");
    cyc(3);

    // 3: level source 1 held across mret, then dropped
    irq_edge_mode = 8'hFD;
    irq_src[1] = 1'b1;
    wait_entry("t3a", 1);
    do_mret("t3a");
    cyc(1);
    chk("t3_reentry", trap_entry_en, 1);
    chk("t3_reidx", int_index, 1);
    irq_src[1] = 1'b0;
    do_mret("t3b");
    no_entry("t3_noentry", 10);
    irq_edge_mode = 8'hFF;

    // 4: global and per-source masking
    int_mstatus_mie = 1'b0;
    pulse(8'h01);
    no_entry("t4_mie_block", 6);
    chk("t4_pend0", irq_pending[0], 1);
    int_mstatus_mie = 1'b1;
    cyc(1);
    chk("t4_mie_entry", trap_entry_en, 1);
    chk("t4_idx0", int_index, 0);
    do_mret("t4a");
    irq_en[4] = 1'b0;
    pulse(8'h10);
    no_entry("t4_en_block", 6);
    chk("t4_pend4", irq_pending[4], 1);
    irq_en[4] = 1'b1;
    cyc(1);
    chk("t4_en_entry", trap_entry_en, 1);
    chk("t4_idx4", int_index, 4);
    do_mret("t4b");
    cyc(3);

    // 5: re-trigger of source 3 while it is being serviced
    pulse(8'h08);
    wait_entry("t5a", 3);
    cyc(1);
    pulse(8'h08);
    cyc(3);
    chk("t5_repend", irq_pending[3], 1);
    chk("t5_still_active", int_active, 1);
    do_mret("t5a");
    wait_entry("t5b", 3);
    do_mret("t5b");
    no_entry("t5_once", 10);

    // 6: reset mid-trap, then stray mret in IDLE
    pulse(8'h40);
    wait_entry("t6", 6);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_active", int_active, 0);
    chk("t6_rst_entry", trap_entry_en, 0);
    chk("t6_rst_exit", trap_exit_en, 0);
    chk("t6_rst_index", int_index, 0);
    chk("t6_rst_pending", irq_pending, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    mret_en = 1'b1;
    cyc(1);
    mret_en = 1'b0;
    repeat (5) begin
      chk("t6_stray_exit", trap_exit_en, 0);
      chk("t6_stray_active", int_active, 0);
      cyc(1);
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) irq_edge_mode = NS'($urandom);
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 19) == 0) irq_src[i] = ~irq_src[i];
      if ($urandom_range(0, 49) == 0) irq_en = NS'($urandom) | NS'($urandom);
      if ($urandom_range(0, 29) == 0) int_mstatus_mie = ~int_mstatus_mie;
      mret_en = ($urandom_range(0, 3) == 0);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
